tdm_demux1x8: RTL
=================

TDM_DEMUX1X8 -- requirements
Module: tdm_demux1x8

Interface
REQ-001 Parameter W, default 8: sample width in bits, legal range 1..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 din  input  W  serial TDM sample for the current slot.
REQ-005 din_valid  input  1  din carries a sample this cycle.
REQ-006 sof  input  1  start of frame; qualified by din_valid; marks the slot-0 sample.
REQ-007 dout  output  8*W  last complete frame; slot k occupies bits [k*W+W-1 : k*W].
REQ-008 frame_valid  output  1  one-cycle pulse when dout has just been updated.
REQ-009 slot  output  3  index the next accepted sample will occupy.
REQ-010 err  output  1  one-cycle framing-error pulse; present only under TDM_DEMUX_ERR_EN.

Function
REQ-011 The block SHALL be a two-state FSM, IDLE and RUN.
REQ-012 IDLE: the block SHALL ignore din_valid without sof.
REQ-013 IDLE: din_valid&sof SHALL store din into shadow slot 0, set slot=1 and enter RUN.
REQ-014 RUN: each din_valid without sof SHALL store din into shadow[slot] and increment slot modulo 8.
REQ-015 RUN: when slot==7 and din_valid is high, the same clock edge SHALL load dout={din, shadow[6:0]}, assert frame_valid for exactly the next cycle and set slot=0; the state SHALL remain RUN.
REQ-016 RUN, slot==0: din_valid&sof SHALL be a normal frame start.
REQ-017 RUN, slot==0: din_valid without sof SHALL be accepted as slot 0 (free-running frames).
REQ-018 RUN, slot!=0: din_valid&sof SHALL discard the partial frame, store din as slot 0, set slot=1 and leave dout unchanged (resync).
REQ-019 The block SHALL hold dout stable between frame_valid pulses; partial frames SHALL never appear on dout.
REQ-020 Latency from acceptance of the slot-7 sample to dout/frame_valid SHALL be 1 cycle.
REQ-021 With din_valid low, the block SHALL change no state.
REQ-022 The block SHALL sustain back-to-back frames at one sample per cycle.

Reset
REQ-023 Reset SHALL set dout=0, frame_valid=0, slot=0, err=0, all shadow registers to 0, and state IDLE.
REQ-024 Reset mid-frame SHALL discard the partial frame, and no frame_valid SHALL follow it.
REQ-025 rst SHALL take priority over din_valid and sof in the same cycle.

Configuration
REQ-026 With TDM_DEMUX_ERR_EN defined, the err port SHALL exist and pulse for one cycle after each resync per REQ-018.
REQ-027 With TDM_DEMUX_ERR_EN defined, err SHALL also pulse after a RUN-state slot-0 sample arriving without sof.
REQ-028 Without TDM_DEMUX_ERR_EN, the err port and its logic SHALL be absent and resync behaviour SHALL be otherwise identical.

Structure
REQ-029 Package tdm_demux_pkg SHALL hold SLOTS=8, the 3-bit slot index type and the IDLE/RUN state enum.
REQ-030 Sub-module demux1x8 SHALL decode slot and din_valid into eight one-hot shadow write enables; it SHALL be purely combinational.

Verification
REQ-031 After reset, dout=0, frame_valid=0, slot=0; samples 0x11..0x88 with sof on the first -> after 0x88, one pulse and dout=0x8877665544332211.
REQ-032 Two frames back-to-back with no gaps -> two pulses 8 cycles apart; second dout correct.
REQ-033 din_valid without sof while IDLE (values 0xAA x5) -> no state change, slot stays 0, no pulse.
REQ-034 sof at slot 4 -> partial frame dropped, dout unchanged, slot=1, err pulse (ERR_EN build only); the following 7 samples complete a frame.
REQ-035 rst asserted at slot 5 -> slot=0, IDLE, no frame_valid; next sof frame decodes correctly.
REQ-036 din_valid gaps of random length between samples -> dout identical to the gap-free case.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_demux_pkg
//  Description : Shared types and constants for the 8-slot TDM demultiplexer:
//                slot count, slot index type and the IDLE/RUN state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package tdm_demux_pkg;

    // Number of TDM slots per frame
    localparam int SLOTS  = 8;
    // Width of a slot index
    localparam int SLOT_W = 3;

    typedef logic [SLOT_W-1:0] slot_t;

    // Highest slot index; accepting this slot completes a frame
    localparam slot_t LAST_SLOT  = 3'd7;
    localparam slot_t FIRST_SLOT = 3'd0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage : tdm_demux_pkg
`default_nettype wire

// File: rtl/tdm_demux1x8_if.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_demux1x8_if
//  Description : Bus bundle between a TDM sample source and the 1x8
//                demultiplexer. The err signal exists only when the
//                TDM_DEMUX_ERR_EN macro is defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface tdm_demux1x8_if #(
    parameter int W = 8
) ();
    import tdm_demux_pkg::*;

    logic [W-1:0]       din;
    logic               din_valid;
    logic               sof;
    logic [SLOTS*W-1:0] dout;
    logic               frame_valid;
    slot_t              slot;
`ifdef TDM_DEMUX_ERR_EN
    logic               err;
`endif

`ifdef TDM_DEMUX_ERR_EN
    // Sample source side
    modport master (
        output din, din_valid, sof,
        input  dout, frame_valid, slot, err
    );
    // Demultiplexer side
    modport slave (
        input  din, din_valid, sof,
        output dout, frame_valid, slot, err
    );
`else
    // Sample source side
    modport master (
        output din, din_valid, sof,
        input  dout, frame_valid, slot
    );
    // Demultiplexer side
    modport slave (
        input  din, din_valid, sof,
        output dout, frame_valid, slot
    );
`endif

endinterface : tdm_demux1x8_if
`default_nettype wire

// File: rtl/tdm_demux1x8_demux1x8.sv
`default_nettype none
// ============================================================================
//  Module      : demux1x8
//  Description : Purely combinational decoder turning a slot index and a
//                write strobe into eight one-hot shadow write enables.
//  Revision    : 1.0  initial release
// ============================================================================
module demux1x8
    import tdm_demux_pkg::*;
(
    input  wire logic       i_valid,
    input  wire slot_t      i_slot,
    output logic [SLOTS-1:0] o_we
);

    // One-hot decode; all enables low when no write is requested
    always_comb begin
        o_we = '0;
        if (i_valid) begin
            o_we[i_slot] = 1'b1;
        end
    end

endmodule : demux1x8
`default_nettype wire

// File: rtl/tdm_demux1x8.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_demux1x8
//  Description : 1-to-8 TDM demultiplexer. Serial samples are collected into
//                shadow registers; the slot-7 sample together with the shadow
//                contents is loaded into dout in one edge, so dout only ever
//                shows complete frames. A sof in mid-frame resynchronises.
//                Optional macro TDM_DEMUX_ERR_EN adds a framing-error pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tdm_demux1x8
    import tdm_demux_pkg::*;
#(
    parameter int W = 8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    tdm_demux1x8_if.slave    bus
);

    state_t             r_state;
    state_t             w_state_nxt;
    slot_t              r_slot;
    slot_t              w_slot_nxt;
    logic [W-1:0]       r_shadow [SLOTS];
    logic [SLOTS*W-1:0] r_dout;
    logic [SLOTS*W-1:0] w_frame;
    logic               r_frame_valid;
    logic               w_load_dout;
    logic               w_wr_en;
    slot_t              w_wr_idx;
    logic [SLOTS-1:0]   w_we;
`ifdef TDM_DEMUX_ERR_EN
    logic               r_err;
    logic               w_err_nxt;
`endif

    // Next-state, slot advance and shadow write selection
    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_wr_en     = 1'b0;
        w_wr_idx    = r_slot;
        w_load_dout = 1'b0;
`ifdef TDM_DEMUX_ERR_EN
        w_err_nxt   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                // Only a start-of-frame sample leaves IDLE
                if (bus.din_valid && bus.sof) begin
                    w_wr_en     = 1'b1;
                    w_wr_idx    = FIRST_SLOT;
                    w_slot_nxt  = 3'd1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.din_valid) begin
                    if (bus.sof) begin
                        // Frame start; anywhere but slot 0 this drops the
                        // partial frame and restarts at slot 0
                        w_wr_en    = 1'b1;
                        w_wr_idx   = FIRST_SLOT;
                        w_slot_nxt = 3'd1;
`ifdef TDM_DEMUX_ERR_EN
                        w_err_nxt  = (r_slot != FIRST_SLOT);
`endif
                    end else if (r_slot == LAST_SLOT) begin
                        // Slot 7 bypasses the shadow and goes straight out
                        w_load_dout = 1'b1;
                        w_slot_nxt  = FIRST_SLOT;
                    end else begin
                        w_wr_en    = 1'b1;
                        w_slot_nxt = r_slot + 3'd1;
`ifdef TDM_DEMUX_ERR_EN
                        // Free-running slot 0 is accepted but flagged
                        w_err_nxt  = (r_slot == FIRST_SLOT);
`endif
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_slot_nxt  = FIRST_SLOT;
            end
        endcase
    end

    demux1x8 u_demux (
        .i_valid (w_wr_en),
        .i_slot  (w_wr_idx),
        .o_we    (w_we)
    );

    // Assemble the outgoing frame: shadow slots 0..6 plus the live slot-7 sample
    always_comb begin
        w_frame = '0;
        for (int k = 0; k < SLOTS - 1; k++) begin
            w_frame[k*W +: W] = r_shadow[k];
        end
        w_frame[(SLOTS-1)*W +: W] = bus.din;
    end

    // State, slot index and output pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_slot        <= FIRST_SLOT;
            r_frame_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_slot        <= w_slot_nxt;
            r_frame_valid <= w_load_dout;
        end
    end

    // Output frame register; changes only when a full frame completes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= '0;
        end else if (w_load_dout) begin
            r_dout <= w_frame;
        end
    end

    // Per-slot shadow registers written through the one-hot enables
    generate
        for (genvar g = 0; g < SLOTS; g++) begin : g_shadow
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_shadow[g] <= '0;
                end else if (w_we[g]) begin
                    r_shadow[g] <= bus.din;
                end
            end
        end
    endgenerate

`ifdef TDM_DEMUX_ERR_EN
    // Framing-error pulse, one cycle after the offending sample
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_nxt;
        end
    end

    assign bus.err = r_err;
`endif

    assign bus.dout        = r_dout;
    assign bus.frame_valid = r_frame_valid;
    assign bus.slot        = r_slot;

endmodule : tdm_demux1x8
`default_nettype wire
